// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_op_t    - request operation encoding
//   lsu_state_t - sequencer states
//   is_store()  - op writes memory
//   access_size() - SZ_B / SZ_H / SZ_W
package lsu_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } lsu_op_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic is_store(lsu_op_t op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

  function automatic logic [1:0] access_size(lsu_op_t op);
    case (op)
      LW, SW:          return SZ_W;
      LH, LHU, SH:     return SZ_H;
      default:         return SZ_B;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_merge.sv
// lsu_align_merge: combinational load extension and store merge.
//   i_op      - operation
//   i_dataout - word read from memory (lane 0 = access address)
//   i_wdata   - right-justified store data
//   o_rdata   - sign/zero extended load result
//   o_wbuf    - full word to write back for SH/SB (wdata for SW)
module lsu_align_merge
  import lsu_pkg::*;
(
  input  lsu_op_t     i_op,
  input  logic [31:0] i_dataout,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wbuf
);

  always_comb begin
    o_rdata = i_dataout;
    case (i_op)
      LH:      o_rdata = {{16{i_dataout[15]}}, i_dataout[15:0]};
      LHU:     o_rdata = {16'h0, i_dataout[15:0]};
      LB:      o_rdata = {{24{i_dataout[7]}}, i_dataout[7:0]};
      LBU:     o_rdata = {24'h0, i_dataout[7:0]};
      default: o_rdata = i_dataout;
    endcase
  end

  // Upper lanes keep what memory already holds; only the low lanes change.
  always_comb begin
    o_wbuf = i_wdata;
    case (i_op)
      SH:      o_wbuf = {i_dataout[31:16], i_wdata[15:0]};
      SB:      o_wbuf = {i_dataout[31:8], i_wdata[7:0]};
      default: o_wbuf = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer in front of a
// 32-bit byte-lane memory with a one-cycle synchronous read.
//   Clk, Reset            - clock, async active-high reset
//   req_valid/ready/op/addr/wdata - request handshake (ready only in IDLE)
//   resp_valid/rdata/err  - one-cycle response pulse
//   mem_raddress/waddress/datain/wr, mem_dataout - memory port
// Sub-word stores are read-modify-write: RD_ADDR -> RD_DATA -> WR.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_W  = 16,
  parameter int CHECK_ALIGN = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  lsu_op_t     req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_raddress,
  output logic [31:0] mem_waddress,
  output logic [31:0] mem_datain,
  output logic        mem_wr,
  input  logic [31:0] mem_dataout
);

  lsu_state_t  r_state, w_next;
  lsu_op_t     r_op;
  logic [31:0] r_addr, r_wdata, r_wbuf, r_rdata;
  logic        r_err;

  logic        w_accept, w_range_err, w_align_err, w_err;
  logic [1:0]  w_size;
  logic [31:0] w_ld_data, w_wbuf;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_size      = access_size(req_op);
  assign w_range_err = |(req_addr >> MEM_ADDR_W);
  assign w_align_err = (CHECK_ALIGN != 0) &&
                       (((w_size == SZ_H) && req_addr[0]) ||
                        ((w_size == SZ_W) && (req_addr[1:0] != 2'b00)));
  assign w_err       = w_range_err || w_align_err;

  lsu_align_merge u_merge (
    .i_op      (r_op),
    .i_dataout (mem_dataout),
    .i_wdata   (r_wdata),
    .o_rdata   (w_ld_data),
    .o_wbuf    (w_wbuf)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)             w_next = S_RESP;
          else if (req_op == SW) w_next = S_WR;
          else                   w_next = S_RD_ADDR;
        end
      end
      S_RD_ADDR: w_next = S_RD_DATA;
      S_RD_DATA: w_next = is_store(r_op) ? S_WR : S_RESP;
      S_WR:      w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_op    <= LW;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wbuf  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_op    <= req_op;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wbuf  <= '0;
      r_rdata <= '0;
      r_err   <= w_err;
    end else if (r_state == S_RD_DATA) begin
      if (is_store(r_op)) r_wbuf  <= w_wbuf;
      else                r_rdata <= w_ld_data;
    end
  end

  // Handshake and write strobe decode straight off the state register so
  // they are glitch-free and drop the instant Reset rises.
  assign req_ready    = (r_state == S_IDLE);
  assign resp_valid   = (r_state == S_RESP);
  assign mem_wr       = (r_state == S_WR);
  assign resp_rdata   = r_rdata;
  assign resp_err     = r_err;
  assign mem_raddress = r_addr;
  assign mem_waddress = r_addr;
  assign mem_datain   = (r_op == SW) ? r_wdata : r_wbuf;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  lsu_op_t     req_op = LW;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_raddress, mem_waddress, mem_datain;
  logic        mem_wr;
  logic [31:0] mem_dataout = '0;

  load_store_unit #(.MEM_ADDR_W(16), .CHECK_ALIGN(1)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_raddress(mem_raddress), .mem_waddress(mem_waddress),
    .mem_datain(mem_datain), .mem_wr(mem_wr), .mem_dataout(mem_dataout)
  );

  always #5 Clk = ~Clk;

  // Byte-lane memory model: lane 0 is the addressed byte, wraps at 64 KiB.
  logic [7:0] mem [0:65535];

  function automatic logic [31:0] mrd(logic [31:0] a);
    logic [15:0] b;
    b = a[15:0];
    return {mem[b + 16'd3], mem[b + 16'd2], mem[b + 16'd1], mem[b]};
  endfunction

  task automatic pre(logic [31:0] a, logic [31:0] d);
    logic [15:0] b;
    b = a[15:0];
    mem[b] = d[7:0]; mem[b + 16'd1] = d[15:8];
    mem[b + 16'd2] = d[23:16]; mem[b + 16'd3] = d[31:24];
  endtask

  always @(posedge Clk) begin
    mem_dataout <= mrd(mem_raddress);
    if (mem_wr) begin
      mem[mem_waddress[15:0]]          <= mem_datain[7:0];
      mem[mem_waddress[15:0] + 16'd1]  <= mem_datain[15:8];
      mem[mem_waddress[15:0] + 16'd2]  <= mem_datain[23:16];
      mem[mem_waddress[15:0] + 16'd3]  <= mem_datain[31:24];
    end
  end

  int cyc = 0;
  int n_acc = 0;
  int n_issued = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready && !Reset) n_acc <= n_acc + 1;
  end

  typedef struct {logic [31:0] rdata; logic err; int lat; int acc;} rexp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; int lat; int acc;} wexp_t;
  rexp_t rq[$];
  wexp_t wq[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a response or write.
  always @(negedge Clk) begin
    rexp_t r;
    wexp_t w;
    if (resp_valid) begin
      if (rq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        r = rq.pop_front();
        chk("resp_rdata", resp_rdata, r.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, r.err});
        chk("resp_latency", cyc - r.acc, r.lat);
      end
    end
    if (mem_wr) begin
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_mem_wr actual=1 expected=0 addr=%h (cycle %0d)", mem_waddress, cyc);
      end else begin
        w = wq.pop_front();
        chk("mem_waddress", mem_waddress, w.addr);
        chk("mem_datain", mem_datain, w.data);
        chk("mem_wr_latency", cyc - w.acc, w.lat);
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic issue(lsu_op_t op, logic [31:0] addr, logic [31:0] wdata,
                       logic [31:0] erd, logic eerr, int lat,
                       logic haswr, logic [31:0] wdat, int wlat,
                       logic push, logic hold);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=0 expected=1 op=%0d addr=%h", op, addr);
    end else begin
      n_issued++;
      if (push) begin
        rq.push_back('{erd, eerr, lat, cyc});
        if (haswr) wq.push_back('{addr, wdat, wlat, cyc});
      end
    end
    @(negedge Clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic ld(lsu_op_t op, logic [31:0] addr, logic [31:0] erd);
    issue(op, addr, 32'h0, erd, 1'b0, 3, 1'b0, 32'h0, 0, 1'b1, 1'b0);
  endtask

  task automatic bad(lsu_op_t op, logic [31:0] addr);
    issue(op, addr, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    pre(32'h100, 32'h8899AABB);
    pre(32'h200, 32'hDEADBEEF);
    pre(32'h300, 32'h11223344);

    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_mem_raddress", mem_raddress, 32'd0);
    chk("rst_mem_waddress", mem_waddress, 32'd0);
    chk("rst_mem_datain", mem_datain, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Loads with extension
    ld(LB,  32'h100, 32'hFFFFFFBB);
    ld(LBU, 32'h100, 32'h000000BB);
    ld(LH,  32'h100, 32'hFFFFAABB);
    ld(LHU, 32'h100, 32'h0000AABB);
    ld(LW,  32'h100, 32'h8899AABB);

    // Sub-word stores via RMW, then read back
    issue(SB, 32'h100, 32'h12345677, 32'h0, 1'b0, 4, 1'b1, 32'h8899AA77, 3, 1'b1, 1'b0);
    ld(LW,  32'h100, 32'h8899AA77);
    ld(LB,  32'h103, 32'hFFFFFF88);
    ld(LHU, 32'h102, 32'h00008899);
    issue(SH, 32'h200, 32'h0000CAFE, 32'h0, 1'b0, 4, 1'b1, 32'hDEADCAFE, 3, 1'b1, 1'b0);
    ld(LW,  32'h200, 32'hDEADCAFE);
    issue(SW, 32'h204, 32'h01020304, 32'h0, 1'b0, 2, 1'b1, 32'h01020304, 1, 1'b1, 1'b0);
    ld(LW,  32'h204, 32'h01020304);

    // Errors: misaligned and out of range
    bad(LW, 32'h102);
    bad(SH, 32'h101);
    bad(LW, 32'h00010000);
    bad(SB, 32'h80000000);

    // Reset during RD_DATA of an SB: no write, no response
    issue(SB, 32'h300, 32'h000000AA, 32'h0, 1'b0, 4, 1'b1, 32'h0, 3, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (6) @(negedge Clk);
    chk("aborted_sb_mem", mrd(32'h300), 32'h11223344);

    // Back-to-back with req_valid held high
    issue(SW,  32'h400, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1, 32'hCAFEF00D, 1, 1'b1, 1'b1);
    issue(LBU, 32'h400, 32'h0, 32'h0000000D, 1'b0, 3, 1'b0, 32'h0, 0, 1'b1, 1'b1);
    issue(SB,  32'h401, 32'h00000055, 32'h0, 1'b0, 4, 1'b1, 32'h00CAFE55, 3, 1'b1, 1'b1);
    issue(LW,  32'h400, 32'h0, 32'hCAFE550D, 1'b0, 3, 1'b0, 32'h0, 0, 1'b1, 1'b0);

    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    repeat (3) @(negedge Clk);
    chk("resp_queue_drained", rq.size(), 32'd0);
    chk("wr_queue_drained", wq.size(), 32'd0);
    chk("accept_count", n_acc, n_issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
